// File: rtl/ps2_keyboard_pkg.sv
// Shared constants, byte classification and status-word packing for the
// PS/2 keyboard receiver peripheral.
package ps2_keyboard_pkg;

  localparam logic [7:0]  SC_BREAK   = 8'hF0;
  localparam logic [7:0]  SC_EXT     = 8'hE0;
  localparam int unsigned FRAME_BITS = 11;

  localparam int unsigned POS_SCANCODE = 0;
  localparam int unsigned POS_BRK      = 8;
  localparam int unsigned POS_EXT      = 9;
  localparam int unsigned POS_ERR      = 10;
  localparam int unsigned POS_COUNT    = 16;

  typedef enum logic [1:0] {
    KIND_KEY,
    KIND_BREAK,
    KIND_EXT
  } byte_kind_t;

  function automatic byte_kind_t classify(input logic [7:0] b);
    if (b == SC_BREAK)    return KIND_BREAK;
    else if (b == SC_EXT) return KIND_EXT;
    else                  return KIND_KEY;
  endfunction

  // Frame is {stop, parity, d7..d0, start}; parity is odd over data+parity.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return !f[0] && f[FRAME_BITS-1] && (^f[FRAME_BITS-2:1]);
  endfunction

  function automatic logic [63:0] pack_status(input logic [7:0]  sc,
                                              input logic        brk,
                                              input logic        ext,
                                              input logic        err,
                                              input logic [15:0] count);
    logic [63:0] w;
    w                     = '0;
    w[POS_SCANCODE +: 8]  = sc;
    w[POS_BRK]            = brk;
    w[POS_EXT]            = ext;
    w[POS_ERR]            = err;
    w[POS_COUNT +: 16]    = count;
    return w;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge detect,
// 11-bit deserialiser with inactivity timeout and frame validation.
module ps2_keyboard_rx
  import ps2_keyboard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);

  logic [1:0]            clk_sync_q, data_sync_q;
  logic                  clk_prev_q;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            byte_q, byte_d;
  logic                  fall;
  logic [FRAME_BITS-1:0] frame_w;

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  // Bits enter at the top so that after 11 shifts the start bit sits at [0].
  assign frame_w = {data_sync_q[1], shift_q[FRAME_BITS-1:1]};

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_d        = tmo_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall) begin
      shift_d = frame_w;
      tmo_d   = '0;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        if (frame_ok(frame_w)) begin
          byte_valid_d = 1'b1;
          byte_d       = frame_w[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != '0) begin
      if (tmo_q == TMO_END) begin
        bit_cnt_d = '0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_q       <= '0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q  <= {data_sync_q[0], ps2_data_i};
      clk_prev_q   <= clk_sync_q[1];
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      byte_q       <= byte_d;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_keyboard.sv
// Memory-mapped PS/2 keyboard peripheral: prefix (E0/F0) decode, 64-bit
// status register and single-address read decode.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter logic [13:0] KBD_ADDRESS    = 14'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic [13:0] address,
  input  logic        PS2_data,
  input  logic        PS2_clk,
  output logic [63:0] data
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  logic [7:0]  scancode_q, scancode_d;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;
  logic        err_q, err_d;
  logic [15:0] count_q, count_d;
  logic        pend_break_q, pend_break_d;
  logic        pend_ext_q, pend_ext_d;

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (system_clk),
    .rst_i       (reset),
    .ps2_clk_i   (PS2_clk),
    .ps2_data_i  (PS2_data),
    .byte_valid_o(byte_valid),
    .byte_o      (rx_byte),
    .frame_err_o (frame_err)
  );

  always_comb begin
    scancode_d   = scancode_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    err_d        = err_q | frame_err;
    count_d      = count_q;
    pend_break_d = pend_break_q;
    pend_ext_d   = pend_ext_q;
    if (byte_valid) begin
      unique case (classify(rx_byte))
        KIND_BREAK: pend_break_d = 1'b1;
        KIND_EXT:   pend_ext_d   = 1'b1;
        default: begin
          scancode_d   = rx_byte;
          brk_d        = pend_break_q;
          ext_d        = pend_ext_q;
          count_d      = count_q + 16'd1;
          pend_break_d = 1'b0;
          pend_ext_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      scancode_q   <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
      pend_break_q <= 1'b0;
      pend_ext_q   <= 1'b0;
    end else begin
      scancode_q   <= scancode_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      err_q        <= err_d;
      count_q      <= count_d;
      pend_break_q <= pend_break_d;
      pend_ext_q   <= pend_ext_d;
    end
  end

  always_comb begin
    data = '0;
    if (address == KBD_ADDRESS)
      data = pack_status(scancode_q, brk_q, ext_q, err_q, count_q);
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard with a register-level reference model and
// a per-cycle compare process.
module tb_ps2_keyboard;

  localparam int unsigned TMO  = 4096;
  localparam int unsigned HALF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] address;
  logic        ps2_data;
  logic        ps2_clk;
  logic [63:0] data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        chk_en = 1'b0;

  // Reference model state
  logic [7:0]  m_sc;
  logic        m_brk, m_ext, m_err, m_pbrk, m_pext;
  logic [15:0] m_count;

  ps2_keyboard #(
    .KBD_ADDRESS   (14'h0000),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .system_clk(clk),
    .reset     (reset),
    .address   (address),
    .PS2_data  (ps2_data),
    .PS2_clk   (ps2_clk),
    .data      (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_word();
    return (64'(m_count) << 16) | (64'(m_err) << 10) | (64'(m_ext) << 9)
         | (64'(m_brk) << 8) | 64'(m_sc);
  endfunction

  task automatic model_reset();
    m_sc = 8'h00; m_brk = 1'b0; m_ext = 1'b0; m_err = 1'b0;
    m_pbrk = 1'b0; m_pext = 1'b0; m_count = 16'h0000;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic bad);
    if (bad) m_err = 1'b1;
    else if (b == 8'hF0) m_pbrk = 1'b1;
    else if (b == 8'hE0) m_pext = 1'b1;
    else begin
      m_sc = b; m_brk = m_pbrk; m_ext = m_pext;
      m_count = m_count + 16'd1;
      m_pbrk = 1'b0; m_pext = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (address != 14'h0000)
      check("unmapped_addr", data, 64'h0);
    else if (chk_en)
      check("model", data, model_word());
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      ps2_data = f[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad);
    chk_en = 1'b0;
    send_bits(make_frame(b, bad), 11);
    cycles(10);
    model_byte(b, bad);
    chk_en = 1'b1;
    cycles(5);
    address = 14'h0001;
    cycles(5);
    address = 14'h0000;
    cycles(5);
  endtask

  task automatic lit(input string name, input logic [63:0] exp);
    @(negedge clk);
    #1;
    check(name, data, exp);
  endtask

  initial begin
    reset = 1'b1; address = 14'h0000; ps2_data = 1'b1; ps2_clk = 1'b1;
    model_reset();
    chk_en = 1'b1;
    cycles(4);
    lit("reset_data", 64'h0);
    address = 14'h0001;
    cycles(2);
    address = 14'h0000;
    reset = 1'b0;
    cycles(5);
    lit("post_reset", 64'h0);

    send_byte(8'h1C, 1'b0);
    lit("make_1C", 64'h0000_0000_0001_001C);

    send_byte(8'hF0, 1'b0);
    lit("prefix_F0_no_commit", 64'h0000_0000_0001_001C);
    send_byte(8'h1C, 1'b0);
    lit("break_1C", 64'h0000_0000_0002_011C);

    address = 14'h0001;
    send_byte(8'hE0, 1'b0);
    address = 14'h0000;
    send_byte(8'h75, 1'b0);
    lit("ext_75", 64'h0000_0000_0003_0275);

    send_byte(8'h1C, 1'b1);
    lit("bad_parity", 64'h0000_0000_0003_0675);
    send_byte(8'h1C, 1'b0);
    lit("err_sticky", 64'h0000_0000_0004_041C);

    chk_en = 1'b0;
    send_bits(make_frame(8'h5A, 1'b0), 5);
    chk_en = 1'b1;
    cycles(TMO + 5);
    send_byte(8'h29, 1'b0);
    lit("after_timeout", 64'h0000_0000_0005_0429);

    chk_en = 1'b0;
    send_bits(make_frame(8'h33, 1'b0), 4);
    cycles(2);
    reset = 1'b1;
    model_reset();
    cycles(3);
    lit("mid_frame_reset", 64'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    cycles(5);
    send_byte(8'h1C, 1'b0);
    lit("after_reset_1C", 64'h0000_0000_0001_001C);

    cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
